// File: rtl/bcd_seg_scan_pkg.sv
// bcd_seg_pkg: shared states, digit width and seven-segment patterns for bcd_seg_scan.
package bcd_seg_pkg;
    typedef enum logic [1:0] {IDLE, SHOW_LO, SHOW_HI} state_e;
    localparam int BCD_W = 4;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/bcd_seg_scan_if.sv
// bcd_seg_if: BCD word handshake plus scanned display outputs.
interface bcd_seg_if;
    logic [7:0] bcd_in;
    logic       bcd_valid;
    logic       bcd_ready;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;
    modport master (output bcd_in, bcd_valid, input bcd_ready, seg, an, err);
    modport slave  (input bcd_in, bcd_valid, output bcd_ready, seg, an, err);
endinterface

// File: rtl/bcd_seg_scan_bcd_to_seg7.sv
// bcd_to_seg7: BCD nibble to {g,f,e,d,c,b,a}; nibbles 10-15 map to a dash.
module bcd_to_seg7
    import bcd_seg_pkg::*;
(
    input  logic [BCD_W-1:0] nib_i,
    output logic [6:0]       seg_o
);
    always_comb begin
        seg_o = SEG_DASH;
        case (nib_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: two-digit scanned 7-seg driver, new words taken only at frame end.
// Optional LEADING_ZERO_BLANK_EN darkens a zero tens digit.
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
) (
    input logic     clk,
    input logic     rst_n,
    bcd_seg_if.slave bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       div_cnt_q, div_cnt_d;
    logic [2*BCD_W-1:0]     bcd_q, bcd_d;
    logic                   err_q, err_d;
    logic                   slot_end, ready, xfer, blank;
    logic [BCD_W-1:0]       nib;
    logic [6:0]             seg7;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bcd_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bcd_q     <= bcd_d;
            err_q     <= err_d;
        end
    end
    always_comb begin
        slot_end  = div_cnt_q == LAST;
        ready     = state_q == IDLE || (state_q == SHOW_HI && slot_end);
        xfer      = bus.bcd_valid && ready;
        div_cnt_d = (state_q == IDLE || slot_end) ? '0 : div_cnt_q + 1'b1;
        state_d   = state_q == SHOW_HI ? (slot_end ? SHOW_LO : SHOW_HI) :
                    state_q == SHOW_LO ? (slot_end ? SHOW_HI : SHOW_LO) :
                    (xfer ? SHOW_LO : IDLE);
        bcd_d     = xfer ? bus.bcd_in : bcd_q;
        err_d     = xfer ? (bus.bcd_in[7:4] > 4'd9 || bus.bcd_in[3:0] > 4'd9) : err_q;
    end
    assign nib = state_q == SHOW_HI ? bcd_q[7:4] : bcd_q[3:0];
    bcd_to_seg7 u_enc (.nib_i(nib), .seg_o(seg7));
`ifdef LEADING_ZERO_BLANK_EN
    assign blank = state_q == SHOW_HI && bcd_q[7:4] == '0;
`else
    assign blank = 1'b0;
`endif
    assign bus.bcd_ready = ready;
    assign bus.an        = blank ? 2'b00 : {state_q == SHOW_HI, state_q == SHOW_LO};
    assign bus.seg       = (blank || state_q == IDLE) ? SEG_BLANK : seg7;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: random and directed words checked against a frame-position model.
module tb_bcd_seg_scan;
    localparam int DIV = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    bcd_seg_if bus ();
    bcd_seg_scan #(.REFRESH_DIV(DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0;
    int fails = 0;
    int pos = -1;
    int pushed = 0;
    int accepted = 0;
    logic [7:0] disp = '0;
    logic merr = 1'b0;
    logic [7:0] q[$];
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask
    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
        return n > 9 ? 7'b1000000 : tab[n];
    endfunction
    task automatic push(input logic [7:0] w);
        q.push_back(w);
        pushed++;
    endtask
    task automatic cycle();
        logic x, er;
        logic [1:0] ea;
        logic [6:0] es;
        bus.bcd_valid = q.size() > 0;
        bus.bcd_in = q.size() > 0 ? q[0] : 8'($urandom);
        @(negedge clk);
        er = pos < 0 || pos == 2 * DIV - 1;
        if (pos < 0) begin ea = 2'b00; es = 7'b0; end
        else if (pos < DIV) begin ea = 2'b01; es = enc(disp[3:0]); end
        else begin ea = 2'b10; es = enc(disp[7:4]); end
`ifdef LEADING_ZERO_BLANK_EN
        if (pos >= DIV && disp[7:4] == 4'd0) begin ea = 2'b00; es = 7'b0; end
`endif
        chk("ready", 16'(bus.bcd_ready), 16'(er));
        chk("an", 16'(bus.an), 16'(ea));
        chk("seg", 16'(bus.seg), 16'(es));
        chk("err", 16'(bus.err), 16'(merr));
        x = bus.bcd_valid && er;
        @(posedge clk);
        #1;
        if (x) begin
            disp = q.pop_front();
            merr = disp[7:4] > 9 || disp[3:0] > 9;
            accepted++;
        end
        pos = pos < 0 ? (x ? 0 : -1) : (pos + 1) % (2 * DIV);
    endtask
    initial begin
        bus.bcd_valid = 1'b0;
        bus.bcd_in = '0;
        #2;
        chk("rst_an", 16'(bus.an), 16'h0);
        chk("rst_seg", 16'(bus.seg), 16'h0);
        chk("rst_ready", 16'(bus.bcd_ready), 16'h1);
        chk("rst_err", 16'(bus.err), 16'h0);
        #10 rst_n = 1'b1;
        repeat (6) cycle();
        push(8'h37);
        repeat (2) cycle();
        push(8'h52);
        repeat (20) cycle();
        push(8'h1C);
        push(8'h09);
        repeat (20) cycle();
        push(8'h05);
        repeat (20) cycle();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) push(8'($urandom));
            cycle();
        end
        for (int i = 0; i < 300 && q.size() > 0; i++) cycle();
        chk("drain", 16'(q.size()), 16'h0);
        chk("accepted", 16'(accepted), 16'(pushed));
        push(8'hA6);
        for (int i = 0; i < 60 && !(disp == 8'hA6 && pos == DIV + 1); i++) cycle();
        chk("reach_hi", 16'(pos), 16'(DIV + 1));
        chk("err_before_rst", 16'(bus.err), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", 16'(bus.an), 16'h0);
        chk("async_seg", 16'(bus.seg), 16'h0);
        chk("async_ready", 16'(bus.bcd_ready), 16'h1);
        chk("async_err", 16'(bus.err), 16'h0);
        q.delete();
        pos = -1;
        disp = '0;
        merr = 1'b0;
        #3 rst_n = 1'b1;
        repeat (10) cycle();
        push(8'h94);
        repeat (12) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
